// File: rtl/lenet_frame_loader.sv
// lenet_frame_loader: streams one 32x32 8-bit image into the accelerator input
// buffer, launches the accelerator, waits for done and offers the class result
// on a valid/ready port.
// Optional watchdog on the accelerator wait: define LOADER_WDT_EN.
module lenet_frame_loader #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 11,
   parameter int unsigned MAX_WIDTH  = 32,
   parameter int unsigned WDT_CYCLES = 50000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   input  logic                  s_last,
   output logic                  s_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic                  acc_start,
   input  logic                  acc_busy,
   input  logic                  acc_done,
   input  logic [DATA_WIDTH-1:0] acc_result,
   output logic                  r_valid,
   output logic [DATA_WIDTH-1:0] r_data,
   input  logic                  r_ready,
   output logic                  frame_err,
   output logic                  timeout,
   output logic                  busy
);

   localparam int unsigned IMG_PIXELS = MAX_WIDTH * MAX_WIDTH;

   typedef enum logic [1:0] {LOAD, START, WAIT, HOLD} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] pix_cnt;
   logic                  accept;
   logic                  last_pix;
   logic                  wdt_fire;

   assign s_ready   = (state == LOAD);
   assign accept    = s_valid & s_ready;
   assign last_pix  = (pix_cnt == ADDR_WIDTH'(IMG_PIXELS - 1));
   assign mem_we    = accept;
   assign mem_addr  = pix_cnt;
   assign mem_wdata = s_data;
   assign r_valid   = (state == HOLD);
   assign busy      = !((state == LOAD) && (pix_cnt == '0));
   assign timeout   = wdt_fire;

`ifdef LOADER_WDT_EN
   localparam int unsigned WDT_W = $clog2(WDT_CYCLES + 1);

   logic [WDT_W-1:0] wdt_cnt;

   // acc_done in the limit cycle takes priority over expiry
   assign wdt_fire = (state == WAIT) && !acc_done && (wdt_cnt == WDT_W'(WDT_CYCLES - 1));

   // Watchdog: counts cycles spent in WAIT, held at zero elsewhere so entry clears it
   always_ff @(posedge clk) begin
      if (!rst_n || state != WAIT) begin
         wdt_cnt <= '0;
      end else begin
         wdt_cnt <= wdt_cnt + WDT_W'(1);
      end
   end
`else
   logic [31:0] unused_wdt;
   assign unused_wdt = WDT_CYCLES;
   assign wdt_fire   = 1'b0;
`endif

   // Next-state and pulse outputs
   always_comb begin
      state_nx  = state;
      acc_start = 1'b0;
      frame_err = 1'b0;
      case (state)
         LOAD: begin
            if (accept && last_pix) state_nx = START;
            // early s_last or missing s_last on the final beat
            frame_err = accept && (last_pix ^ s_last);
         end
         START: begin
            if (!acc_busy) begin
               acc_start = 1'b1;
               state_nx  = WAIT;
            end
         end
         WAIT: begin
            if (acc_done || wdt_fire) state_nx = HOLD;
         end
         HOLD: begin
            if (r_ready) state_nx = LOAD;
         end
         default: state_nx = LOAD;
      endcase
   end

   // State register, pixel counter and result capture
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state   <= LOAD;
         pix_cnt <= '0;
         r_data  <= '0;
      end else begin
         state <= state_nx;
         if (accept) begin
            pix_cnt <= (last_pix || s_last) ? '0 : pix_cnt + ADDR_WIDTH'(1);
         end
         if (state == WAIT) begin
            if (acc_done) begin
               r_data <= acc_result;
            end else if (wdt_fire) begin
               r_data <= '1;
            end
         end
      end
   end

endmodule
